// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep controllers: state encoding,
// default sweep geometry and the golden table of the team's 4-input function.
package tt_sweep_pkg;

   localparam int N_IN_DEFAULT = 4;
   localparam int NVEC         = 1 << N_IN_DEFAULT;

   // Minterms 0, 2, 5, 7, 11, 14 of the 4-input dataflow function.
   localparam logic [NVEC-1:0] EXPECTED_DEFAULT = 16'h48A5;

   // Settle counter width; holds the largest legal settle time (15).
   localparam int SETTLE_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t DRIVE  = 2'd1;
   localparam state_t SAMPLE = 2'd2;
   localparam state_t DONE   = 2'd3;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter. Expiry is flagged while the count sits at zero, so a
// load of N-1 gives N cycles before the owner sees expired.
module settle_timer
   import tt_sweep_pkg::*;
#(
   parameter int WIDTH = SETTLE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // Count down from the loaded value and park at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweep controller: drives every input vector of an external
// combinational function, samples its output after a settle time, and scores
// the captured truth table against a golden table.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int                     N_IN          = N_IN_DEFAULT,
   parameter int                     SETTLE_CYCLES = 1,
   parameter logic [(1<<N_IN)-1:0]   EXPECTED      = EXPECTED_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   f_in,
   output logic [N_IN-1:0]        vec_out,
   output logic                   vec_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic [N_IN:0]          fail_count,
   output logic [N_IN-1:0]        first_fail_idx
);

   localparam logic [N_IN-1:0]     LAST_IDX    = '1;
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   state_t          state;
   logic [N_IN-1:0] idx;
   logic            timer_load;
   logic            timer_expired;
   logic            sweeping;

   assign sweeping = (state == DRIVE) || (state == SAMPLE);

   // Restart the settle time whenever a new vector goes onto vec_out.
   always_comb begin
      // NOTE: a default assignment first keeps this purely combinational; a
      // path that leaves it unassigned would infer a latch.
      timer_load = 1'b0;
      if (state == IDLE && start && !abort) begin
         timer_load = 1'b1;
      end else if (state == SAMPLE && !abort && idx != LAST_IDX) begin
         timer_load = 1'b1;
      end
   end

   settle_timer #(
      .WIDTH (SETTLE_W)
   ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (timer_load),
      .load_value (SETTLE_LOAD),
      .expired    (timer_expired)
   );

   // Sweep FSM, vector index and scoreboard; every output is a register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the captured table is a plain register vector, not a memory, so
      // it is reset alongside the rest of the state.
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         vec_out        <= '0;
         vec_valid      <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         table_out      <= '0;
         fail_count     <= '0;
         first_fail_idx <= '0;
      end else begin
         done <= 1'b0;
         if (sweeping && abort) begin
            // Abort wins over everything, including the final sample; the
            // partial table and count are left for inspection.
            state     <= IDLE;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            pass      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state          <= DRIVE;
                     idx            <= '0;
                     vec_out        <= '0;
                     vec_valid      <= 1'b1;
                     busy           <= 1'b1;
                     pass           <= 1'b0;
                     table_out      <= '0;
                     fail_count     <= '0;
                     first_fail_idx <= '0;
                  end
               end
               DRIVE: begin
                  if (timer_expired) begin
                     state <= SAMPLE;
                  end
               end
               SAMPLE: begin
                  table_out[idx] <= f_in;
                  if (f_in != EXPECTED[idx]) begin
                     fail_count <= fail_count + 1'b1;
                     if (fail_count == '0) begin
                        first_fail_idx <= idx;
                     end
                  end
                  if (idx == LAST_IDX) begin
                     state     <= DONE;
                     vec_out   <= '0;
                     vec_valid <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     state   <= DRIVE;
                     idx     <= idx + 1'b1;
                     vec_out <= idx + 1'b1;
                  end
               end
               DONE: begin
                  // fail_count already includes the last sample here.
                  done  <= 1'b1;
                  pass  <= (fail_count == '0);
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
